// File: rtl/ds_pkg.sv
// rtl/ds_pkg.sv - DS link control codes, character lengths and tx state type
package ds_pkg;

    // Codes are written in wire order: bit [1] is transmitted first.
    localparam logic [1:0] CODE_FCT  = 2'b00;
    localparam logic [1:0] CODE_EOP1 = 2'b01;
    localparam logic [1:0] CODE_EOP2 = 2'b10;
    localparam logic [1:0] CODE_ESC  = 2'b11;

    localparam int CTRL_LEN = 4;
    localparam int DATA_LEN = 10;

    typedef enum logic {
        ST_OFF  = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    // Character images are shifted out from bit 0.
    function automatic logic [9:0] ctrl_char(input logic p, input logic [1:0] code);
        return {6'b000000, code[0], code[1], 1'b1, p};
    endfunction

    function automatic logic [9:0] data_char(input logic p, input logic [7:0] d);
        return {d, 1'b0, p};
    endfunction

endpackage

// File: rtl/ds_tx_bittick.sv
// rtl/ds_tx_bittick.sv - one-cycle bit-boundary strobe every G_BIT_DIV cycles
module ds_tx_bittick #(
    parameter int G_BIT_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(G_BIT_DIV - 1);

    logic [7:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/ds_tx.sv
// rtl/ds_tx.sv - data-strobe link transmitter with holding register and NULL fill
// Optional flow-control request input enabled by defining DS_TX_FCT_EN.
module ds_tx
    import ds_pkg::*;
#(
    parameter int G_BIT_DIV            = 1,
    parameter int G_LINK_PARITY_IS_ODD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] tx_data,
    input  logic       tx_eop,
    input  logic       tx_valid,
`ifdef DS_TX_FCT_EN
    input  logic       fct_req,
`endif
    output logic       tx_ready,
    output logic       d_out,
    output logic       s_out
);

    localparam logic ODD = (G_LINK_PARITY_IS_ODD != 0);

    tx_state_t   state;
    tx_state_t   state_nxt;
    logic        tick;
    logic        step;
    logic        boundary;
    logic        go_off;
    logic        load;
    logic [9:0]  sh;
    logic [3:0]  bits_left;
    logic        prev_par;
    logic        null_half;
    logic        hold_full;
    logic [7:0]  hold_data;
    logic        hold_eop;
    logic        fct_pend;
    logic [1:0]  code;
    logic        is_data;
    logic        take_hold;
    logic        start_null;
    logic        flag;
    logic        char_par;
    logic        p_bit;
    logic [9:0]  new_char;
    logic [3:0]  len_m1;
    logic        next_bit;

    ds_tx_bittick #(.G_BIT_DIV(G_BIT_DIV)) u_bittick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state == ST_SEND),
        .tick  (tick)
    );

    // Leaving OFF counts as a bit boundary so the first bit appears one cycle after en.
    assign step     = (state == ST_OFF) ? en : tick;
    assign boundary = step && (bits_left == 4'd0);
    assign go_off   = (state == ST_SEND) && boundary && !en && !null_half;
    assign load     = boundary && !go_off;
    assign tx_ready = !hold_full;

    always_comb begin
        code       = CODE_ESC;
        is_data    = 1'b0;
        take_hold  = 1'b0;
        start_null = 1'b0;
        if (null_half) begin
            code = CODE_FCT;
        end else if (fct_pend) begin
            code = CODE_FCT;
        end else if (hold_full) begin
            take_hold = 1'b1;
            if (hold_eop) begin
                code = CODE_EOP1;
            end else begin
                is_data = 1'b1;
            end
        end else begin
            start_null = 1'b1;
        end
    end

    assign flag     = !is_data;
    assign char_par = is_data ? ^hold_data : ^code;
    assign p_bit    = ODD ? !(prev_par ^ flag) : (prev_par ^ flag);
    assign new_char = is_data ? data_char(p_bit, hold_data) : ctrl_char(p_bit, code);
    assign len_m1   = is_data ? 4'(DATA_LEN - 1) : 4'(CTRL_LEN - 1);
    assign next_bit = load ? new_char[0] : sh[0];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF:  if (en)     state_nxt = ST_SEND;
            ST_SEND: if (go_off) state_nxt = ST_OFF;
            default:             state_nxt = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_out     <= 1'b0;
            s_out     <= 1'b0;
            sh        <= '0;
            bits_left <= '0;
            prev_par  <= 1'b0;
            null_half <= 1'b0;
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_eop  <= 1'b0;
        end else begin
            if (tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
                hold_eop  <= tx_eop;
            end
            if (go_off) begin
                d_out <= 1'b0;
                s_out <= 1'b0;
            end else if (step) begin
                // Strobe toggles only when data repeats, so exactly one line changes.
                if (next_bit == d_out) begin
                    s_out <= !s_out;
                end
                d_out <= next_bit;
                if (load) begin
                    sh        <= new_char >> 1;
                    bits_left <= len_m1;
                    prev_par  <= char_par;
                    null_half <= start_null;
                    if (take_hold) begin
                        hold_full <= 1'b0;
                    end
                end else begin
                    sh        <= sh >> 1;
                    bits_left <= bits_left - 4'd1;
                end
            end
        end
    end

`ifdef DS_TX_FCT_EN
    logic [2:0] fct_cnt;
    logic       fct_dec;

    assign fct_pend = (fct_cnt != 3'd0);
    assign fct_dec  = load && !null_half && fct_pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fct_cnt <= '0;
        end else if (fct_req && !fct_dec) begin
            if (fct_cnt != 3'd7) begin
                fct_cnt <= fct_cnt + 3'd1;
            end
        end else if (!fct_req && fct_dec) begin
            fct_cnt <= fct_cnt - 3'd1;
        end
    end
`else
    assign fct_pend = 1'b0;
`endif

endmodule
